// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the execute-stage back end.
// Holds the datapath width, the op_kind encoding, the branch funct3 codes,
// the pre-resolved write-back entry layout and the branch condition helper.
package rv32i_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      OP_ALU    = 2'b00,
      OP_SLT    = 2'b01,
      OP_BRANCH = 2'b10,
      OP_JUMP   = 2'b11
   } op_kind_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Entries are resolved before buffering, so the skid buffer never needs
   // to know which instruction produced them.
   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [4:0]      rd;
      logic            regWrite;
   } wb_entry_t;

   // Branch condition from the ALU comparison flags; the two unused funct3
   // codes (010, 011) resolve to not-taken so they behave as no-ops.
   function automatic logic branchTaken(input logic [2:0] funct3,
                                        input logic eq,
                                        input logic lu,
                                        input logic ls);
      logic taken;
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = eq;
         F3_BNE:  taken = ~eq;
         F3_BLT:  taken = ls;
         F3_BGE:  taken = ~ls;
         F3_BLTU: taken = lu;
         F3_BGEU: taken = ~lu;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/ex_result_stage_if.sv
// Bus bundle between the ALU/decode side, ex_result_stage, the memory stage
// and fetch. The slave modport is the stage itself; the master modport is
// whatever surrounds it (upstream driver, memory stage, fetch).
// Upstream:   in_valid/in_ready, alu_s, alu_eq/lu/ls, op_kind, funct3, pc,
//             br_target, rd, reg_write, flush
// Downstream: out_valid/out_ready, out_result, out_rd, out_reg_write
// Fetch:      redirect_valid, redirect_pc
interface ex_result_stage_if;
   import rv32i_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] alu_s;
   logic            alu_eq;
   logic            alu_lu;
   logic            alu_ls;
   op_kind_e        op_kind;
   logic [2:0]      funct3;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] br_target;
   logic [4:0]      rd;
   logic            reg_write;
   logic            flush;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [4:0]      out_rd;
   logic            out_reg_write;

   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output in_valid, alu_s, alu_eq, alu_lu, alu_ls, op_kind, funct3, pc,
             br_target, rd, reg_write, flush, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_reg_write,
             redirect_valid, redirect_pc
   );

   modport slave (
      input  in_valid, alu_s, alu_eq, alu_lu, alu_ls, op_kind, funct3, pc,
             br_target, rd, reg_write, flush, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_reg_write,
             redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ex_result_stage_skid_buffer.sv
// skid_buffer: two-entry valid/ready buffer with flush.
// The main register drives the output; the skid register catches one entry
// that arrives while main is stalled. inReady_o comes straight from the skid
// valid flop, so there is no combinational path from outReady_i to it.
// Ports: clk, rst_n (async active-low), flush_i, inValid_i/inReady_o/inData_i,
//        outValid_o/outReady_i/outData_o.
module skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             inValid_i,
   output logic             inReady_o,
   input  logic [WIDTH-1:0] inData_i,
   output logic             outValid_o,
   input  logic             outReady_i,
   output logic [WIDTH-1:0] outData_o
);

   logic             mainValid_q, mainValid_d;
   logic             skidValid_q, skidValid_d;
   logic [WIDTH-1:0] mainData_q,  mainData_d;
   logic [WIDTH-1:0] skidData_q,  skidData_d;
   logic             accept;

   // An input is only taken while the skid slot is free; a flush cycle
   // discards whatever is presented.
   assign accept = inValid_i & ~skidValid_q & ~flush_i;

   // Next-state selection. Skid full implies main full, so when the skid is
   // occupied the only legal move is skid -> main on a drain, which keeps
   // entries in order.
   always_comb begin
      mainValid_d = mainValid_q;
      skidValid_d = skidValid_q;
      mainData_d  = mainData_q;
      skidData_d  = skidData_q;
      if (flush_i) begin
         mainValid_d = 1'b0;
         skidValid_d = 1'b0;
      end else if (skidValid_q) begin
         if (outReady_i) begin
            mainData_d  = skidData_q;
            skidValid_d = 1'b0;
         end
      end else if (!mainValid_q || outReady_i) begin
         mainValid_d = accept;
         if (accept) begin
            mainData_d = inData_i;
         end
      end else if (accept) begin
         skidValid_d = 1'b1;
         skidData_d  = inData_i;
      end
   end

   // State registers; reset empties both slots and zeroes the payloads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainValid_q <= 1'b0;
         skidValid_q <= 1'b0;
         mainData_q  <= '0;
         skidData_q  <= '0;
      end else begin
         mainValid_q <= mainValid_d;
         skidValid_q <= skidValid_d;
         mainData_q  <= mainData_d;
         skidData_q  <= skidData_d;
      end
   end

   assign inReady_o  = ~skidValid_q;
   assign outValid_o = mainValid_q;
   assign outData_o  = mainData_q;

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage: registered execute back end after the ALU.
// Selects the write-back value (ALU, SLT/SLTU, JUMP link, BRANCH zero),
// resolves conditional branches and jumps, buffers the resolved entry in a
// two-entry skid buffer toward the memory stage, and pulses a one-cycle PC
// redirect for every accepted taken control transfer.
// Ports: clk, rst_n (async active-low), bus (ex_result_stage_if.slave).
module ex_result_stage
   import rv32i_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   ex_result_stage_if.slave   bus
);

   wb_entry_t       inEntry;
   wb_entry_t       outEntry;
   logic            taken;
   logic [XLEN-1:0] target;
   logic            accept;

   logic            redirectValid_q, redirectValid_d;
   logic [XLEN-1:0] redirectPc_q,    redirectPc_d;

   // Resolve the incoming instruction into a write-back entry and decide
   // whether it transfers control. Writes to x0 and all branches are
   // dropped here so the memory stage never sees a bogus enable.
   always_comb begin
      inEntry.rd       = bus.rd;
      inEntry.regWrite = bus.reg_write && (bus.rd != 5'd0) &&
                         (bus.op_kind != OP_BRANCH);
      inEntry.result   = '0;
      taken            = 1'b0;
      target           = bus.br_target;
      case (bus.op_kind)
         OP_ALU: begin
            inEntry.result = bus.alu_s;
         end
         OP_SLT: begin
            inEntry.result = {{(XLEN-1){1'b0}},
                              bus.funct3[0] ? bus.alu_lu : bus.alu_ls};
         end
         OP_BRANCH: begin
            taken = branchTaken(bus.funct3, bus.alu_eq, bus.alu_lu, bus.alu_ls);
         end
         OP_JUMP: begin
            inEntry.result = bus.pc + XLEN'(4);
            taken          = 1'b1;
            target         = bus.alu_s & ~XLEN'(1);
         end
         default: begin
            inEntry.result = '0;
         end
      endcase
   end

   assign accept = bus.in_valid & bus.in_ready & ~bus.flush;

   // The redirect flag is simply "a taken transfer was accepted last edge",
   // so it self-clears; the target holds its last value when idle.
   always_comb begin
      redirectValid_d = accept & taken;
      redirectPc_d    = (accept & taken) ? target : redirectPc_q;
   end

   // Redirect registers, independent of downstream backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirectValid_q <= 1'b0;
         redirectPc_q    <= '0;
      end else begin
         redirectValid_q <= redirectValid_d;
         redirectPc_q    <= redirectPc_d;
      end
   end

   skid_buffer #(
      .WIDTH($bits(wb_entry_t))
   ) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (bus.flush),
      .inValid_i  (bus.in_valid),
      .inReady_o  (bus.in_ready),
      .inData_i   (inEntry),
      .outValid_o (bus.out_valid),
      .outReady_i (bus.out_ready),
      .outData_o  (outEntry)
   );

   assign bus.out_result     = outEntry.result;
   assign bus.out_rd         = outEntry.rd;
   assign bus.out_reg_write  = outEntry.regWrite;
   assign bus.redirect_valid = redirectValid_q;
   assign bus.redirect_pc    = redirectPc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: directed vectors with literal
// expectations, plus a queue-based reference model checked every cycle.
module tb_ex_result_stage;
   import rv32i_pkg::*;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        regWrite;
   } exp_entry_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   passes = 0;

   exp_entry_t  expQ[$];
   logic        expRv  = 1'b0;
   logic [31:0] expRpc = 32'h0;

   ex_result_stage_if bus();

   ex_result_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-wide comparison with a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
   endtask

   // Reference rules for one instruction.
   function automatic logic modelTaken(input op_kind_e op, input logic [2:0] f3,
                                       input logic eq, input logic lu, input logic ls);
      if (op == OP_JUMP) return 1'b1;
      if (op != OP_BRANCH) return 1'b0;
      case (f3)
         3'b000: return eq;
         3'b001: return !eq;
         3'b100: return ls;
         3'b101: return !ls;
         3'b110: return lu;
         3'b111: return !lu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_entry_t modelEntry();
      exp_entry_t e;
      e.rd = bus.rd;
      e.regWrite = bus.reg_write && (bus.rd != 0) && (bus.op_kind != OP_BRANCH);
      case (bus.op_kind)
         OP_ALU:  e.result = bus.alu_s;
         OP_SLT:  e.result = (bus.funct3[0] ? bus.alu_lu : bus.alu_ls) ? 32'd1 : 32'd0;
         OP_JUMP: e.result = bus.pc + 32'd4;
         default: e.result = 32'd0;
      endcase
      return e;
   endfunction

   // Reference model: a FIFO of at most two entries plus a redirect flag.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         expQ.delete();
         expRv  <= 1'b0;
         expRpc <= 32'h0;
      end else begin
         logic acc;
         logic tk;
         acc = bus.in_valid && (expQ.size() < 2) && !bus.flush;
         tk  = acc && modelTaken(bus.op_kind, bus.funct3, bus.alu_eq, bus.alu_lu, bus.alu_ls);
         expRv <= tk;
         if (tk) expRpc <= (bus.op_kind == OP_JUMP) ? (bus.alu_s & 32'hFFFF_FFFE) : bus.br_target;
         if (bus.flush) begin
            expQ.delete();
         end else begin
            if (expQ.size() > 0 && bus.out_ready) void'(expQ.pop_front());
            if (acc) expQ.push_back(modelEntry());
         end
      end
   end

   // Compare process on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkBit("rst out_valid", bus.out_valid, 1'b0);
         checkBit("rst redirect_valid", bus.redirect_valid, 1'b0);
         checkBit("rst in_ready", bus.in_ready, 1'b1);
         checkOutput("rst out_result", bus.out_result, 32'h0);
         checkOutput("rst redirect_pc", bus.redirect_pc, 32'h0);
      end else begin
         checkBit("model in_ready", bus.in_ready, expQ.size() < 2);
         checkBit("model out_valid", bus.out_valid, expQ.size() > 0);
         if (expQ.size() > 0) begin
            checkOutput("model out_result", bus.out_result, expQ[0].result);
            checkOutput("model out_rd", {27'b0, bus.out_rd}, {27'b0, expQ[0].rd});
            checkBit("model out_reg_write", bus.out_reg_write, expQ[0].regWrite);
         end
         checkBit("model redirect_valid", bus.redirect_valid, expRv);
         if (expRv) checkOutput("model redirect_pc", bus.redirect_pc, expRpc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input op_kind_e op, input logic [2:0] f3,
                                input logic [31:0] aluS, input logic eq,
                                input logic lu, input logic ls,
                                input logic [31:0] pcV, input logic [31:0] brT,
                                input logic [4:0] rdV, input logic rw);
      bus.in_valid  = 1'b1;
      bus.op_kind   = op;
      bus.funct3    = f3;
      bus.alu_s     = aluS;
      bus.alu_eq    = eq;
      bus.alu_lu    = lu;
      bus.alu_ls    = ls;
      bus.pc        = pcV;
      bus.br_target = brT;
      bus.rd        = rdV;
      bus.reg_write = rw;
   endtask

   logic [7:0] takenMap;
   logic [2:0] f3v;

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;  bus.op_kind = OP_ALU; bus.funct3 = 3'b0;
      bus.alu_s = 32'h0;    bus.alu_eq = 1'b0;    bus.alu_lu = 1'b0;
      bus.alu_ls = 1'b0;    bus.pc = 32'h0;       bus.br_target = 32'h0;
      bus.rd = 5'd0;        bus.reg_write = 1'b0; bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      step(); step();
      rst_n = 1'b1;

      // Put a jump in flight, then reset mid-stream.
      applyStimulus(OP_JUMP, 3'b000, 32'h81, 0, 0, 0, 32'h40, 32'h0, 5'd2, 1);
      step();
      checkBit("pre-reset redirect", bus.redirect_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      checkBit("async rst out_valid", bus.out_valid, 1'b0);
      checkBit("async rst redirect_valid", bus.redirect_valid, 1'b0);
      checkBit("async rst in_ready", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      step();
      rst_n = 1'b1;

      // First ALU op after reset.
      applyStimulus(OP_ALU, 3'b000, 32'h12345678, 0, 0, 0, 32'h0, 32'h0, 5'd5, 1);
      step();
      checkOutput("alu result", bus.out_result, 32'h12345678);
      checkOutput("alu rd", {27'b0, bus.out_rd}, 32'd5);
      checkBit("alu reg_write", bus.out_reg_write, 1'b1);

      // SLT / SLTU flag selection.
      applyStimulus(OP_SLT, 3'b010, 32'h0, 0, 0, 1, 32'h0, 32'h0, 5'd6, 1);
      step();
      checkOutput("slt ls=1", bus.out_result, 32'd1);
      applyStimulus(OP_SLT, 3'b011, 32'h0, 0, 0, 1, 32'h0, 32'h0, 5'd6, 1);
      step();
      checkOutput("sltu lu=0", bus.out_result, 32'd0);
      // Flags from A=0xC0000000, B=0xFFFFF000: signed and unsigned both less.
      applyStimulus(OP_SLT, 3'b010, 32'h0, 0, 1, 1, 32'h0, 32'h0, 5'd7, 1);
      step();
      checkOutput("slt C0000000", bus.out_result, 32'd1);
      applyStimulus(OP_SLT, 3'b011, 32'h0, 0, 1, 1, 32'h0, 32'h0, 5'd7, 1);
      step();
      checkOutput("sltu C0000000", bus.out_result, 32'd1);

      // Branch sweep with eq=0, lu=1, ls=0: taken for 001, 101, 110.
      takenMap = 8'b0110_0010;
      for (int i = 0; i < 8; i++) begin
         f3v = 3'(i);
         applyStimulus(OP_BRANCH, f3v, 32'h0, 0, 1, 0, 32'h80, 32'h100, 5'd3, 1);
         step();
         checkBit($sformatf("branch f3=%0d redirect", i), bus.redirect_valid, takenMap[i]);
         checkBit($sformatf("branch f3=%0d reg_write", i), bus.out_reg_write, 1'b0);
         if (takenMap[i]) checkOutput($sformatf("branch f3=%0d pc", i), bus.redirect_pc, 32'h100);
      end

      // Jump with wrapping link address and LSB-cleared target.
      applyStimulus(OP_JUMP, 3'b000, 32'h00000203, 0, 0, 0, 32'hFFFFFFFC, 32'h0, 5'd1, 1);
      step();
      checkOutput("jump link", bus.out_result, 32'h0);
      checkOutput("jump target", bus.redirect_pc, 32'h00000202);
      checkBit("jump redirect", bus.redirect_valid, 1'b1);
      bus.in_valid = 1'b0;
      step();
      checkBit("jump pulse ends", bus.redirect_valid, 1'b0);

      // Backpressure: three ops offered, two fit.
      bus.out_ready = 1'b0;
      applyStimulus(OP_ALU, 3'b000, 32'hA1, 0, 0, 0, 32'h0, 32'h0, 5'd9, 1);
      step();
      checkBit("bp in_ready after 1", bus.in_ready, 1'b1);
      applyStimulus(OP_ALU, 3'b000, 32'hA2, 0, 0, 0, 32'h0, 32'h0, 5'd10, 1);
      step();
      checkBit("bp in_ready after 2", bus.in_ready, 1'b0);
      checkOutput("bp head", bus.out_result, 32'hA1);
      applyStimulus(OP_ALU, 3'b000, 32'hA3, 0, 0, 0, 32'h0, 32'h0, 5'd11, 1);
      step();
      checkBit("bp in_ready held", bus.in_ready, 1'b0);
      checkOutput("bp head held", bus.out_result, 32'hA1);
      bus.out_ready = 1'b1;
      step();
      checkOutput("bp drain 2nd", bus.out_result, 32'hA2);
      checkBit("bp in_ready rises", bus.in_ready, 1'b1);
      step();
      checkOutput("bp third accepted", bus.out_result, 32'hA3);
      bus.in_valid = 1'b0;
      step();
      checkBit("bp empty", bus.out_valid, 1'b0);

      // Flush with both entries full and a taken branch on the input.
      bus.out_ready = 1'b0;
      applyStimulus(OP_ALU, 3'b000, 32'hB1, 0, 0, 0, 32'h0, 32'h0, 5'd12, 1);
      step();
      applyStimulus(OP_ALU, 3'b000, 32'hB2, 0, 0, 0, 32'h0, 32'h0, 5'd13, 1);
      step();
      applyStimulus(OP_BRANCH, F3_BEQ, 32'h0, 1, 0, 0, 32'h0, 32'h200, 5'd0, 0);
      bus.flush = 1'b1;
      step();
      checkBit("flush out_valid", bus.out_valid, 1'b0);
      checkBit("flush redirect", bus.redirect_valid, 1'b0);
      checkBit("flush in_ready", bus.in_ready, 1'b1);
      // Flush on an empty stage still suppresses the redirect.
      bus.out_ready = 1'b1;
      step();
      checkBit("flush empty redirect", bus.redirect_valid, 1'b0);
      checkBit("flush empty out_valid", bus.out_valid, 1'b0);
      bus.flush = 1'b0;

      // Mixed traffic with intermittent backpressure, checked by the model.
      for (int i = 0; i < 24; i++) begin
         bus.out_ready = (i % 3) != 0;
         if (i % 4 == 3) applyStimulus(OP_BRANCH, 3'(i), 32'h0, i[0], i[1], i[2],
                                       32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 5'(i), 1);
         else if (i % 5 == 4) applyStimulus(OP_JUMP, 3'b000, 32'h3001 + 32'(i), 0, 0, 0,
                                            32'h400 + 32'(i * 4), 32'h0, 5'(i % 2), 1);
         else applyStimulus(OP_ALU, 3'b000, 32'hC000 + 32'(i), 0, 0, 0, 32'h0, 32'h0,
                            5'(i + 1), i[0]);
         bus.in_valid = (i % 7) != 6;
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step(); step(); step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ex_result_stage.md
# ex_result_stage

Registered execute-stage back end placed directly downstream of the ALU. It consumes the ALU's S/EQ/LU/LS outputs plus instruction control fields, and resolves SLT/SLTU results, conditional branches and jumps. It buffers one result in a 2-entry skid buffer with valid/ready handshakes toward the memory stage, and issues a one-cycle PC redirect for taken control transfers.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an instruction with settled ALU outputs
- in_ready  out  1  stage can accept; equals !skid_valid
- alu_s  in  XLEN  ALU result S
- alu_eq, alu_lu, alu_ls  in  1 each  ALU comparisons A==B, A<B unsigned, A<B signed
- op_kind  in  2  00 ALU, 01 SET_LT, 10 BRANCH, 11 JUMP
- funct3  in  3  instruction funct3
- pc  in  XLEN  instruction PC
- br_target  in  XLEN  precomputed PC+imm for branches
- rd  in  5  destination register
- reg_write  in  1  instruction writes rd
- flush  in  1  kill all buffered entries and this cycle's input
- out_valid  out  1  out_* fields valid
- out_ready  in  1  memory stage accepts
- out_result  out  XLEN  write-back value
- out_rd  out  5  destination register
- out_reg_write  out  1  write enable (forced 0 for BRANCH and for rd==0)
- redirect_valid  out  1  one-cycle pulse: fetch must go to redirect_pc
- redirect_pc  out  XLEN  redirect target

## Operation
- Result select:
  - ALU: alu_s
  - SET_LT: {31'b0, funct3[0] ? alu_lu : alu_ls}
  - JUMP: pc+4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000)
  - BRANCH: 0
- Branch taken by funct3:
  - 000 eq
  - 001 !eq
  - 100 ls
  - 101 !ls
  - 110 lu
  - 111 !lu
  - 010 and 011: never taken, treated as a no-op
- Redirect target:
  - BRANCH taken: br_target
  - JUMP: alu_s & ~32'h1 (JAL and JALR both route the target through the ALU)
- Accept condition: in_valid && in_ready && !flush.
- Entries are stored pre-resolved (result, rd, write enable), so the skid buffer is data-agnostic.
- Skid buffer: main register drives out_*, skid register holds overflow.
  - Accept while main is empty or draining: data goes to main.
  - Accept while main holds and !out_ready: data goes to skid.
  - out_ready with skid full: skid moves to main.
  - Order is always preserved.
- Redirect: an accepted taken BRANCH or JUMP sets redirect_valid and redirect_pc at the next edge. redirect_valid deasserts on the following edge unless another taken transfer is accepted.
- Redirect is independent of out_ready. Upstream squashes younger instructions; this stage never does so itself.
- Flush: main and skid valids clear at the next edge. No redirect is generated for an input presented in the flush cycle. A redirect already asserted still completes its single cycle.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - out_valid=0, redirect_valid=0, skid_valid=0
  - out_result, out_rd, out_reg_write, redirect_pc all 0
  - in_ready=1
- Latency: accepted at edge N, visible on out_* after edge N.
- Redirect visible after edge N, for exactly one cycle.
- Throughput: 1 per cycle with out_ready held high.
- in_ready is a register output with no combinational path from out_ready.
  - It falls the cycle after the skid fills.
  - It rises the cycle after the skid drains.
- Accept and drain in the same cycle with only main full: the new entry goes to main, and out_valid stays 1.
- Reset asserted mid-transfer discards all entries and any pending redirect.

## Structure
- Shared package rv32i_pkg holds:
  - op_kind encoding constants: OP_ALU, OP_SLT, OP_BRANCH, OP_JUMP
  - branch funct3 constants: F3_BEQ … F3_BGEU
  - XLEN
- Sub-module skid_buffer (parameter WIDTH) implements the 2-entry valid/ready buffer with flush.
- ex_result_stage wraps skid_buffer and adds result select, branch resolution and redirect logic.

## Test plan
- Reset: rst_n=0 mid-stream -> out_valid=0, redirect_valid=0, in_ready=1 immediately. After release, first accepted ALU op alu_s=0x12345678, rd=5 -> out_result=0x12345678, out_rd=5, out_reg_write=1 one edge later.
- SET_LT, alu_ls=1, alu_lu=0:
  - funct3=010 -> out_result=1
  - funct3=011 -> out_result=0
  - A=0xC0000000, B=0xFFFFF000 ALU flags -> SLT=1, SLTU=1
- Branch funct3 sweep 000-111, eq=0, lu=1, ls=0, br_target=0x100:
  - redirect pulses only for 001, 101, 110, with redirect_pc=0x100
  - out_reg_write=0 for all eight
- JUMP with pc=0xFFFFFFFC, alu_s=0x00000203, rd=1 -> out_result=0x00000000, redirect_pc=0x00000202, one-cycle pulse.
- Backpressure: out_ready=0 while 3 ops offered back-to-back -> 2 accepted, in_ready=0 from the cycle after the second. out_ready=1 -> ops drain in order over 2 cycles, then the third is accepted.
- Flush with both entries full plus a taken branch on the input -> out_valid=0 next cycle, no redirect, in_ready=1.
